// File: rtl/sw_top.sv
// Stopwatch: button debounce, BCD time 00.00-59.99 with minute count on LEDs,
// lap hold and multiplexed 7-segment scan. All board outputs registered.

module sw_db #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q, s1_d, s2_q, s2_d, acc_q, acc_d, prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d   = btn;
    s2_d   = s1_q;
    prev_d = acc_q;
    acc_d  = acc_q;
    cnt_d  = '0;
    // cnt_q counts consecutive cycles the synchronized level differs from acc_q
    if (s2_q != acc_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) acc_d = s2_q;
      else                                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0; s2_q <= 1'b0; acc_q <= 1'b0; prev_q <= 1'b0; cnt_q <= '0;
    end else begin
      s1_q <= s1_d; s2_q <= s2_d; acc_q <= acc_d; prev_q <= prev_d; cnt_q <= cnt_d;
    end
  end

  assign press = acc_q & ~prev_q;
endmodule

module sw_top #(
  parameter int unsigned TICK_DIV        = 1_000_000,
  parameter int unsigned REFRESH_DIV     = 100_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BTNC,
  input  logic        BTND,
  input  logic        BTNU,
  input  logic        BTNL,
  input  logic        BTNR,
  output logic [11:0] SEG,
  output logic [7:0]  LED
);
  localparam int NUM_BTN = 3;
  localparam int PW      = $clog2(TICK_DIV + 1);
  localparam int RW      = $clog2(REFRESH_DIV + 1);

  logic [NUM_BTN-1:0] btn_raw, press;
  logic               unused_btn;
  assign btn_raw    = {BTNU, BTND, BTNC};
  assign unused_btn = BTNL ^ BTNR;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    sw_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(CLK), .rst_n(RESET), .btn(btn_raw[g]), .press(press[g])
    );
  end

  logic            running_q, running_d, lap_q, lap_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0][3:0] dig_q, dig_d, latch_q, latch_d;
  logic [6:0]      min_q, min_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic [1:0]      idx_q, idx_d;
  logic [11:0]     seg_q, seg_d;
  logic [7:0]      led_q, led_d;
  logic            tick, clr, carry;
  logic [3:0]      shown, lim;
  logic [6:0]      segs;

  always_comb begin
    tick      = running_q && (presc_q == PW'(TICK_DIV - 1));
    // start/stop wins over a simultaneous clear; clear only acts while stopped
    clr       = press[1] && !press[0] && !running_q;
    running_d = running_q ^ press[0];
    presc_d   = presc_q;
    dig_d     = dig_q;
    min_d     = min_q;
    carry     = 1'b0;
    lim       = 4'd9;
    if (clr) begin
      presc_d = '0;
      dig_d   = '0;
      min_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      carry   = 1'b1;
      for (int i = 0; i < 4; i++) begin
        lim = (i == 3) ? 4'd5 : 4'd9;
        if (carry) begin
          if (dig_q[i] == lim) dig_d[i] = 4'd0;
          else begin
            dig_d[i] = dig_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
      if (carry) min_d = min_q + 7'd1;
    end else if (running_q) begin
      presc_d = presc_q + PW'(1);
    end

    lap_d   = clr ? 1'b0 : (lap_q ^ press[2]);
    latch_d = (press[2] && !lap_q && !clr) ? dig_q : latch_q;

    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      ref_d = ref_q + RW'(1);
      idx_d = idx_q;
    end

    shown = lap_q ? latch_q[idx_q] : dig_q[idx_q];
    case (shown)
      4'd0: segs = 7'h40;  4'd1: segs = 7'h79;  4'd2: segs = 7'h24;
      4'd3: segs = 7'h30;  4'd4: segs = 7'h19;  4'd5: segs = 7'h12;
      4'd6: segs = 7'h02;  4'd7: segs = 7'h78;  4'd8: segs = 7'h00;
      4'd9: segs = 7'h10;  default: segs = 7'h7F;
    endcase
    seg_d = {~(4'b0001 << idx_q), (idx_q != 2'd2), segs};
    led_d = {min_d, running_d};
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      running_q <= 1'b0;  lap_q <= 1'b0;  presc_q <= '0;
      dig_q     <= '0;    latch_q <= '0;  min_q <= '0;
      ref_q     <= '0;    idx_q <= '0;
      seg_q     <= 12'hEC0;
      led_q     <= 8'h00;
    end else begin
      running_q <= running_d;  lap_q <= lap_d;  presc_q <= presc_d;
      dig_q     <= dig_d;      latch_q <= latch_d;  min_q <= min_d;
      ref_q     <= ref_d;      idx_q <= idx_d;
      seg_q     <= seg_d;
      led_q     <= led_d;
    end
  end

  assign SEG = seg_q;
  assign LED = led_q;
endmodule

// File: tb/tb_sw_top.sv
// Directed bench for sw_top with small dividers; BCD time model derived from
// edge counts between observed start/stop events.

module tb_sw_top;
  logic        CLK = 1'b0, RESET, BTNC, BTND, BTNU, BTNL, BTNR;
  logic [11:0] SEG;
  logic [7:0]  LED;
  int tests = 0, fails = 0, cyc = 0;

  sw_top #(.TICK_DIV(2), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .BTNC(BTNC), .BTND(BTND), .BTNU(BTNU),
    .BTNL(BTNL), .BTNR(BTNR), .SEG(SEG), .LED(LED)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int t);
    int s;
    s = t % 6000;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] dec7(input logic [6:0] s);
    case (s)
      7'h40: return 4'd0;  7'h79: return 4'd1;  7'h24: return 4'd2;
      7'h30: return 4'd3;  7'h19: return 4'd4;  7'h12: return 4'd5;
      7'h02: return 4'd6;  7'h78: return 4'd7;  7'h00: return 4'd8;
      7'h10: return 4'd9;  default: return 4'hF;
    endcase
  endfunction

  task automatic wait_led0(input logic v, output int stamp, output bit ok);
    ok = 0; stamp = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (LED[0] === v) begin ok = 1; stamp = cyc; break; end
    end
  endtask

  task automatic wait_lap(input logic v, output int stamp, output bit ok);
    ok = 0; stamp = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (dut.lap_q === v) begin ok = 1; stamp = cyc; break; end
    end
  endtask

  // one full scan; digits gathered by anode, DP must be low only on digit 2
  task automatic read_disp(output logic [15:0] d, output bit dp_ok);
    d = 16'hFFFF; dp_ok = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      case (SEG[11:8])
        4'b1110: d[3:0]   = dec7(SEG[6:0]);
        4'b1101: d[7:4]   = dec7(SEG[6:0]);
        4'b1011: d[11:8]  = dec7(SEG[6:0]);
        4'b0111: d[15:12] = dec7(SEG[6:0]);
        default: dp_ok = 0;
      endcase
      if (SEG[7] !== (SEG[11:8] != 4'b1011)) dp_ok = 0;
    end
  endtask

  task automatic hold_btnd(input int n);
    BTND = 1'b1;
    repeat (n) @(negedge CLK);
    BTND = 1'b0;
    repeat (12) @(negedge CLK);
  endtask

  logic [11:0] scan_exp [4];
  logic [15:0] d, explap;
  bit          ok, dpok;
  int          e, s, l;

  initial begin
    scan_exp = '{12'hEC0, 12'hDC0, 12'hB40, 12'h7C0};
    RESET = 1'b0; BTNC = 0; BTND = 0; BTNU = 0; BTNL = 0; BTNR = 0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("reset_seg", SEG, 12'hEC0);
    chk("reset_led", LED, 8'h00);
    RESET = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      chk($sformatf("scan_%0d", k), SEG, scan_exp[((k - 1) / 4) % 4]);
    end
    chk("idle_led", LED, 8'h00);

    // start, count 200 cycles = 100 hundredths
    BTNC = 1'b1; wait_led0(1'b1, e, ok); BTNC = 1'b0;
    chk("start_seen", ok, 1);
    repeat (200) @(posedge CLK);
    @(negedge CLK);
    chk("count_0100", dut.dig_q, 16'h0100);

    BTNC = 1'b1; repeat (3) @(negedge CLK); BTNC = 1'b0;
    repeat (20) @(negedge CLK);
    chk("glitch_running", LED[0], 1);
    chk("glitch_dig", dut.dig_q, bcd((cyc - e) / 2));

    BTNC = 1'b1; wait_led0(1'b0, s, ok); BTNC = 1'b0;
    chk("stop_seen", ok, 1);
    chk("stop_dig", dut.dig_q, bcd((s - e) / 2));
    repeat (20) @(negedge CLK);
    chk("freeze_dig", dut.dig_q, bcd((s - e) / 2));

    hold_btnd(12);
    chk("clear_led", LED, 8'h00);
    read_disp(d, dpok);
    chk("clear_disp", d, 16'h0000);
    chk("clear_dp", dpok, 1);

    // clear while running is ignored, then two minute rollovers
    BTNC = 1'b1; wait_led0(1'b1, e, ok); BTNC = 1'b0;
    chk("start2_seen", ok, 1);
    repeat (10) @(negedge CLK);
    hold_btnd(12);
    chk("clr_run_led0", LED[0], 1);
    chk("clr_run_dig", dut.dig_q, bcd((cyc - e) / 2));
    while (cyc - e < 12020) @(negedge CLK);
    chk("roll1_dig", dut.dig_q, bcd((cyc - e) / 2));
    chk("roll1_led", LED, 8'h03);
    force dut.min_q = 7'd127;
    @(posedge CLK);
    @(negedge CLK);
    release dut.min_q;
    chk("force_led", LED, 8'hFF);
    while (cyc - e < 24020) @(negedge CLK);
    chk("roll2_dig", dut.dig_q, bcd((cyc - e) / 2));
    chk("roll2_led", LED, 8'h01);
    BTNC = 1'b1; wait_led0(1'b0, s, ok); BTNC = 1'b0;
    chk("stop2_seen", ok, 1);
    repeat (12) @(negedge CLK);
    hold_btnd(12);
    chk("clear2_led", LED, 8'h00);

    // lap hold near 00.50; unused buttons wiggled throughout
    BTNC = 1'b1; wait_led0(1'b1, e, ok); BTNC = 1'b0;
    chk("start3_seen", ok, 1);
    while (cyc - e < 100) @(negedge CLK);
    BTNU = 1'b1; BTNL = 1'b1; wait_lap(1'b1, l, ok); BTNU = 1'b0;
    chk("lap_on_seen", ok, 1);
    explap = bcd((l - 1 - e) / 2);
    BTNR = 1'b1;
    repeat (20) @(negedge CLK);
    read_disp(d, dpok);
    chk("lap_disp", d, explap);
    chk("lap_dp", dpok, 1);
    chk("lap_live", dut.dig_q, bcd((cyc - e) / 2));
    chk("lap_led", LED, 8'h01);
    BTNL = 1'b0; BTNR = 1'b0;
    BTNU = 1'b1; wait_lap(1'b0, l, ok); BTNU = 1'b0;
    chk("lap_off_seen", ok, 1);
    repeat (15) @(negedge CLK);
    BTNC = 1'b1; wait_led0(1'b0, s, ok); BTNC = 1'b0;
    chk("stop3_seen", ok, 1);
    repeat (12) @(negedge CLK);
    read_disp(d, dpok);
    chk("live_disp", d, bcd((s - e) / 2));

    // reset mid-count
    BTNC = 1'b1; wait_led0(1'b1, e, ok); BTNC = 1'b0;
    chk("start4_seen", ok, 1);
    repeat (30) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("midreset_seg", SEG, 12'hEC0);
    chk("midreset_led", LED, 8'h00);
    RESET = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sw_top.md
# sw_top

Stopwatch top level for the board's four-digit multiplexed 7-segment display and LED bank. It debounces the push-buttons and counts elapsed time in hundredths of a second from 00.00 to 59.99, with a minute count on the LEDs. It also scans the BCD time onto the display. It sits directly under the board pin wrapper; all board I/O is registered here.

## Interface
- TICK_DIV, 1_000_000: CLK cycles per 0.01 s tick (100 MHz clock).
- REFRESH_DIV, 100_000: CLK cycles per display digit slot.
- DEBOUNCE_CYCLES, 500_000: consecutive stable synchronized cycles required to accept a button level.
- CLK  in  1  system clock; the only clock.
- RESET  in  1  reset, synchronous, active-low.
- BTNC  in  1  start/stop toggle.
- BTND  in  1  clear; acts only while stopped.
- BTNU  in  1  lap hold toggle.
- BTNL, BTNR  in  1 each  unused; must not affect any output.
- SEG  out  12  [11:8] anodes, active-low one-hot, bit 8 = rightmost digit; [7] decimal point, active-low; [6:0] segments gfedcba, active-low.
- LED  out  8  [0] running flag; [7:1] completed minutes, modulo 128.

## Operation
- Each button passes through a 2-flop synchronizer and then a debouncer. A level is accepted after DEBOUNCE_CYCLES stable cycles. A rising edge of the accepted level gives a 1-cycle press pulse. Release generates no event.
- running toggles on each BTNC press.
- A prescaler counts while running. When it reaches TICK_DIV-1 it wraps to 0 and the time advances 0.01 s. The prescaler holds its value while stopped.
- Time is held as 4 BCD digits: d3 tens of seconds (0-5), d2 seconds (0-9), d1 tenths (0-9), d0 hundredths (0-9). Digits cascade with carries.
- At 59.99 the next tick gives 00.00 and the minute count increments. The minute count wraps from 127 to 0.
- A BTND press while stopped clears the time digits, the minute count and the prescaler. A BTND press while running is ignored.
- If BTNC and BTND pulse in the same cycle, BTNC acts and BTND is ignored.
- Lap hold: a BTNU press toggles the lap state.
  - Entering lap copies the live digits into a display latch; counting continues underneath.
  - Leaving lap returns the display to the live digits.
  - Clear also leaves lap.
- Scan: a refresh counter advances a 2-bit digit index every REFRESH_DIV cycles, in the order 0,1,2,3,0. The anode for index i is low and all others are high.
  - Segments show the selected digit's BCD value; codes 0-9 are standard and any other code blanks the digit (all segments high).
  - DP is lit (0) only on digit 2, marking SS.hh.
- LED[0] equals running. LED[7:1] equals the minute count. The LEDs reflect live state, not the lap latch.

## Timing
- All state updates on the CLK rising edge. All outputs are registered.
- Reset (RESET=0 sampled on a rising edge) sets:
  - running, lap, time, minutes, prescaler, refresh counter and digit index all to 0;
  - the debouncer accepted levels to 0.
- Reset has priority over every other event, including mid-count and mid-debounce.
- Outputs after reset: SEG = 12'hEC0 (digit 0 selected, showing "0", DP off) and LED = 8'h00.
- Press latency: input edge to press pulse = 2 synchronizer + DEBOUNCE_CYCLES + 1 cycles. Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- Tick on the same cycle as a stopping BTNC pulse: the tick is applied, then running clears.
- A stopped-then-restarted watch resumes from the held prescaler value, so there is no lost fraction.
- SEG updates one cycle after a digit-index change.

## Test plan
- Reset: hold RESET=0 for 10 cycles → SEG=12'hEC0, LED=0; stays so with no button activity.
- Start/count, with TICK_DIV=2, REFRESH_DIV=4, DEBOUNCE_CYCLES=4: pulse BTNC for 20 cycles → LED[0]=1; 2 cycles per hundredth; after 200 further cycles digits read 01.00.
- Stop/debounce: 3-cycle BTNC glitch → no change. A 20-cycle BTNC pulse while running → LED[0]=0 and digits freeze. A BTND press then gives 00.00 and LED=0.
- Clear while running: BTND press → ignored, count continues.
- Rollover: run past 59.99 → digits 00.00 and LED[7:1]=1. Force the minute count to 127 → the next rollover gives 0.
- Lap/scan: a BTNU press at 00.50 keeps the displayed digits at 00.50 while LED and the internal count advance. A second BTNU press shows live time. The anodes cycle 1110→1101→1011→0111 every 4 cycles, with DP low only on anode 1011.
